// File: rtl/uart_rx_framer.sv
// 8N1 asynchronous serial receiver with a fixed clock divisor, mid-bit sampling and
// framing-error detection. Bytes are delivered LSB-first with a one-cycle strobe.
module uart_rx_framer #(
  parameter int unsigned DIVISOR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rxd,
  output logic [7:0] uart_rxd,
  output logic       uart_rxd_strobe,
  output logic       framing_error
);

  localparam int unsigned HALF = DIVISOR / 2;
  localparam int unsigned CW   = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    StBreak,
    StIdle,
    StStart,
    StData,
    StStop
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;

  logic            w_rx;
  logic            w_tick;

  assign w_rx   = r_sync2;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_state         <= StBreak;
      r_cnt           <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      uart_rxd        <= '0;
      uart_rxd_strobe <= 1'b0;
      framing_error   <= 1'b0;
    end else begin
      r_sync1         <= serial_rxd;
      r_sync2         <= r_sync1;
      uart_rxd_strobe <= 1'b0;
      framing_error   <= 1'b0;
      unique case (r_state)
        // Need three consecutive high samples so the preset-high synchronizer
        // contents cannot release a line that is actually still held low.
        StBreak: begin
          if (w_rx) begin
            if (r_cnt == CW'(2)) begin
              r_state <= StIdle;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
        StIdle: begin
          if (!w_rx) begin
            r_state <= StStart;
            r_cnt   <= HALF_LOAD;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (w_rx) begin
              r_state <= StIdle;
            end else begin
              r_state   <= StData;
              r_cnt     <= DIV_LOAD;
              r_bit_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        StData: begin
          if (w_tick) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= DIV_LOAD;
            if (r_bit_cnt == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        StStop: begin
          if (w_tick) begin
            if (w_rx) begin
              uart_rxd        <= r_shift;
              uart_rxd_strobe <= 1'b1;
              r_state         <= StIdle;
            end else begin
              framing_error <= 1'b1;
              r_state       <= StBreak;
              r_cnt         <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= StBreak;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: one DIVISOR=16 instance and one DIVISOR=4 instance.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  logic       clk;
  logic       reset;
  logic       serial_a;
  logic       serial_b;
  logic [7:0] rxd_a;
  logic [7:0] rxd_b;
  logic       stb_a;
  logic       stb_b;
  logic       fe_a;
  logic       fe_b;

  int n_checks;
  int n_fail;
  int cyc;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int fe_cnt_a;
  int fe_cnt_b;
  int both_cnt;
  int long_cnt;
  int strobe_cyc_a;
  logic prev_stb_a;
  logic prev_fe_a;

  uart_rx_framer #(.DIVISOR(16)) dut_a (
    .clk             (clk),
    .reset           (reset),
    .serial_rxd      (serial_a),
    .uart_rxd        (rxd_a),
    .uart_rxd_strobe (stb_a),
    .framing_error   (fe_a)
  );

  uart_rx_framer #(.DIVISOR(4)) dut_b (
    .clk             (clk),
    .reset           (reset),
    .serial_rxd      (serial_b),
    .uart_rxd        (rxd_b),
    .uart_rxd_strobe (stb_b),
    .framing_error   (fe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record what the DUTs emit; the tasks compare these records against expectations.
  always @(negedge clk) begin
    if (stb_a) begin
      q_a.push_back(rxd_a);
      strobe_cyc_a = cyc;
    end
    if (stb_b) q_b.push_back(rxd_b);
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if ((stb_a && fe_a) || (stb_b && fe_b)) both_cnt++;
    if ((stb_a && prev_stb_a) || (fe_a && prev_fe_a)) long_cnt++;
    prev_stb_a = stb_a;
    prev_fe_a  = fe_a;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input realtime bit_ns, input logic stop_val,
                           input bit sel_b);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel_b) serial_b = frame[i];
      else       serial_a = frame[i];
      #(bit_ns);
    end
    if (sel_b) serial_b = 1'b1;
    else       serial_a = 1'b1;
  endtask

  task automatic test_reset;
    idle(3);
    n_checks += 4;
    if (rxd_a !== 8'h00) begin n_fail++; $display("FAIL reset_rxd: got %h want 00", rxd_a); end
    if (stb_a !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", stb_a); end
    if (fe_a !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", fe_a); end
    if (rxd_b !== 8'h00) begin n_fail++; $display("FAIL reset_rxd_b: got %h want 00", rxd_b); end
    reset = 1'b0;
    idle(20);
  endtask

  task automatic test_single_byte;
    int start_cyc;
    q_a.delete();
    fe_cnt_a = 0;
    @(negedge clk);
    start_cyc = cyc;
    send_byte(8'h21, 160.0, 1'b1, 1'b0);
    idle(30);
    n_checks += 4;
    if (q_a.size() !== 1) begin
      n_fail++; $display("FAIL single_count: got %0d want 1", q_a.size());
    end else if (q_a[0] !== 8'h21) begin
      n_fail++; $display("FAIL single_data: got %h want 21", q_a[0]);
    end
    if (fe_cnt_a !== 0) begin n_fail++; $display("FAIL single_fe: got %0d want 0", fe_cnt_a); end
    if (strobe_cyc_a - start_cyc !== 155) begin
      n_fail++; $display("FAIL single_latency: got %0d want 155", strobe_cyc_a - start_cyc);
    end
    if (rxd_a !== 8'h21) begin n_fail++; $display("FAIL single_hold: got %h want 21", rxd_a); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[3];
    exp = '{8'h52, 8'h00, 8'hFF};
    q_a.delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(exp[i], 160.0, 1'b1, 1'b0);
    idle(30);
    n_checks++;
    if (q_a.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 3", q_a.size());
    end
    for (int i = 0; i < 3 && i < q_a.size(); i++) begin
      n_checks++;
      if (q_a[i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, q_a[i], exp[i]);
      end
    end
  endtask

  task automatic test_glitch;
    q_a.delete();
    fe_cnt_a = 0;
    @(negedge clk);
    serial_a = 1'b0;
    idle(4);
    serial_a = 1'b1;
    idle(40);
    n_checks += 2;
    if (q_a.size() !== 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d want 0", q_a.size()); end
    if (fe_cnt_a !== 0) begin n_fail++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt_a); end
    send_byte(8'h57, 160.0, 1'b1, 1'b0);
    idle(30);
    n_checks++;
    if (q_a.size() !== 1 || q_a[0] !== 8'h57) begin
      n_fail++; $display("FAIL glitch_next: got %0d bytes last %h want 1 byte 57", q_a.size(), rxd_a);
    end
  endtask

  task automatic test_framing_error;
    q_a.delete();
    fe_cnt_a = 0;
    @(negedge clk);
    send_byte(8'hA5, 160.0, 1'b0, 1'b0);
    serial_a = 1'b0;
    idle(40);
    serial_a = 1'b1;
    idle(30);
    n_checks += 3;
    if (fe_cnt_a !== 1) begin n_fail++; $display("FAIL fe_count: got %0d want 1", fe_cnt_a); end
    if (q_a.size() !== 0) begin n_fail++; $display("FAIL fe_strobe: got %0d want 0", q_a.size()); end
    if (rxd_a !== 8'h57) begin n_fail++; $display("FAIL fe_hold: got %h want 57", rxd_a); end
    send_byte(8'h56, 160.0, 1'b1, 1'b0);
    idle(30);
    n_checks++;
    if (q_a.size() !== 1 || rxd_a !== 8'h56) begin
      n_fail++; $display("FAIL fe_next: got %0d bytes last %h want 1 byte 56", q_a.size(), rxd_a);
    end
  endtask

  task automatic test_reset_mid_frame;
    q_a.delete();
    fe_cnt_a = 0;
    @(negedge clk);
    serial_a = 1'b0;        // start bit plus data bits 0..2 of 0x00
    #(160.0 * 4 + 80.0);    // into the middle of data bit 3
    reset = 1'b1;
    idle(2);
    n_checks += 3;
    if (rxd_a !== 8'h00) begin n_fail++; $display("FAIL midrst_rxd: got %h want 00", rxd_a); end
    if (stb_a !== 1'b0) begin n_fail++; $display("FAIL midrst_strobe: got %b want 0", stb_a); end
    if (fe_a !== 1'b0) begin n_fail++; $display("FAIL midrst_fe: got %b want 0", fe_a); end
    reset = 1'b0;
    idle(300);
    n_checks += 2;
    if (q_a.size() !== 0) begin n_fail++; $display("FAIL midrst_low_strobe: got %0d want 0", q_a.size()); end
    if (fe_cnt_a !== 0) begin n_fail++; $display("FAIL midrst_low_fe: got %0d want 0", fe_cnt_a); end
    serial_a = 1'b1;
    idle(20);
    send_byte(8'h33, 160.0, 1'b1, 1'b0);
    idle(30);
    n_checks++;
    if (q_a.size() !== 1 || rxd_a !== 8'h33) begin
      n_fail++; $display("FAIL midrst_next: got %0d bytes last %h want 1 byte 33", q_a.size(), rxd_a);
    end
  endtask

  task automatic test_baud_tolerance;
    realtime rates[2];
    rates = '{154.0, 166.0};
    for (int i = 0; i < 2; i++) begin
      q_a.delete();
      fe_cnt_a = 0;
      @(negedge clk);
      send_byte(8'h5A, rates[i], 1'b1, 1'b0);
      idle(30);
      n_checks++;
      if (q_a.size() !== 1 || rxd_a !== 8'h5A || fe_cnt_a !== 0) begin
        n_fail++;
        $display("FAIL tol_%0d: got %0d bytes last %h fe %0d want 1 byte 5a fe 0",
                 i, q_a.size(), rxd_a, fe_cnt_a);
      end
    end
  endtask

  task automatic test_small_divisor;
    logic [7:0] exp[2];
    exp = '{8'h5A, 8'hC3};
    q_b.delete();
    fe_cnt_b = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) send_byte(exp[i], 40.0, 1'b1, 1'b1);
    idle(20);
    n_checks += 2;
    if (q_b.size() !== 2) begin n_fail++; $display("FAIL div4_count: got %0d want 2", q_b.size()); end
    if (fe_cnt_b !== 0) begin n_fail++; $display("FAIL div4_fe: got %0d want 0", fe_cnt_b); end
    for (int i = 0; i < 2 && i < q_b.size(); i++) begin
      n_checks++;
      if (q_b[i] !== exp[i]) begin
        n_fail++; $display("FAIL div4_data[%0d]: got %h want %h", i, q_b[i], exp[i]);
      end
    end
  endtask

  task automatic test_strobe_hygiene;
    n_checks += 2;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    if (long_cnt !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d want 0", long_cnt); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    fe_cnt_a     = 0;
    fe_cnt_b     = 0;
    both_cnt     = 0;
    long_cnt     = 0;
    strobe_cyc_a = 0;
    prev_stb_a   = 1'b0;
    prev_fe_a    = 1'b0;
    reset        = 1'b1;
    serial_a     = 1'b1;
    serial_b     = 1'b1;
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_glitch;
    test_framing_error;
    test_reset_mid_frame;
    test_baud_tolerance;
    test_small_divisor;
    test_strobe_hygiene;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
